// File: rtl/scan_code_gen.sv
// Multiplexed 7-segment scan driver: cycles digit codes 1..NUM_DIGITS with registered segments.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 1 always shown).
module scan_code_gen #(
  parameter int SCAN_DIV       = 50000,
  parameter int NUM_DIGITS     = 6,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] digits,
  output logic [2:0]  code,
  output logic        en,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_SCAN   = 1'b1;
  localparam logic [7:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [PW-1:0] PRESC_TC  = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    LAST_CODE = 3'(NUM_DIGITS);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;
  logic [23:0]   pending_q, pending_d;
  logic [23:0]   active_q, active_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_for(input logic [23:0] dbuf, input logic [2:0] c);
    logic [3:0] nib;
    logic       blank;
    logic [7:0] pat;
    nib   = 4'h0;
    blank = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++)
      if (3'(k) == c) nib = dbuf[4*k-4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more-significant scanned digit are zero.
    if (c >= 3'd2) begin
      blank = 1'b1;
      for (int k = 2; k <= NUM_DIGITS; k++)
        if (3'(k) >= c && dbuf[4*k-4 +: 4] != 4'h0) blank = 1'b0;
    end
`endif
    pat = {1'b0, hex7(nib)};
    if (blank)                    seg_for = SEG_OFF;
    else if (SEG_ACTIVE_LOW != 0) seg_for = ~pat;
    else                          seg_for = pat;
  endfunction

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    code_d       = code_q;
    seg_d        = seg_q;
    active_d     = active_q;
    frame_done_d = 1'b0;
    pending_d    = load ? digits : pending_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_SCAN;
          code_d   = 3'd1;
          presc_d  = '0;
          active_d = pending_d;
          seg_d    = seg_for(active_d, 3'd1);
        end
      end
      default: begin
        if (!run) begin
          state_d = ST_IDLE;
          code_d  = 3'd0;
          presc_d = '0;
          seg_d   = SEG_OFF;
        end else if (presc_q == PRESC_TC) begin
          presc_d = '0;
          if (code_q == LAST_CODE) begin
            // Frame wrap is the only in-scan point where new digits become visible.
            code_d       = 3'd1;
            active_d     = pending_d;
            frame_done_d = 1'b1;
          end else begin
            code_d = code_q + 3'd1;
          end
          seg_d = seg_for(active_d, code_d);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      code_q       <= 3'd0;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      pending_q    <= '0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      code_q       <= code_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
    end
  end

  assign code       = code_q;
  assign en         = (state_q == ST_SCAN);
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_code_gen.sv
// Randomized bench for scan_code_gen against a time-since-start reference model.
// Honors LEADING_ZERO_BLANK_EN when defined for the build.
module tb_scan_code_gen;
  localparam int SD = 4;
  localparam int ND = 6;

  logic        clk = 1'b0;
  logic        rst, run, load;
  logic [23:0] digits;
  logic [2:0]  code;
  logic        en;
  logic [7:0]  seg;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scanning flag, cycles since scan start, buffers.
  bit          m_run = 1'b0;
  int          m_t   = 0;
  logic [23:0] m_pend = '0;
  logic [23:0] m_act  = '0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] e2 [6] = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] e6 [6] = '{8'h92, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF};
`else
  logic [7:0] e6 [6] = '{8'h92, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
`endif

  scan_code_gen #(.SCAN_DIV(SD), .NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .run(run), .load(load), .digits(digits),
    .code(code), .en(en), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [23:0] d, input int k);
    logic [23:0] upper;
    logic [3:0]  nib;
    upper = d >> (4 * (k - 1));
    nib   = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (k >= 2 && upper == 24'h0) return 8'hFF;
`endif
    return ~{1'b0, hex_tab[nib]};
  endfunction

  task automatic model_step(input logic rs, input logic r, input logic ld, input logic [23:0] dg);
    logic [23:0] pn;
    if (rs) begin
      m_run = 1'b0; m_t = 0; m_pend = '0; m_act = '0;
    end else begin
      pn = ld ? dg : m_pend;
      if (!r) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0; m_act = pn;
      end else begin
        m_t++;
        if (m_t % (SD * ND) == 0) m_act = pn;
      end
      m_pend = pn;
    end
  endtask

  task automatic cyc(input logic rs, input logic r, input logic ld, input logic [23:0] dg);
    int exp_code;
    rst = rs; run = r; load = ld; digits = dg;
    @(posedge clk);
    model_step(rs, r, ld, dg);
    #1;
    exp_code = m_run ? ((m_t / SD) % ND + 1) : 0;
    chk("code", 32'(code), 32'(exp_code));
    chk("en", 32'(en), 32'(m_run));
    chk("seg", 32'(seg), m_run ? 32'(ref_seg(m_act, exp_code)) : 32'hFF);
    chk("frame_done", 32'(frame_done), 32'(m_run && m_t > 0 && (m_t % (SD * ND) == 0)));
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] dg;
    rst = 1'b1; run = 1'b0; load = 1'b0; digits = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 24'h123456);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0);
      chk("t1_seg", 32'(seg), 32'hFF);
    end

    cyc(0, 0, 1, 24'h012345);
    for (int i = 0; i < 48; i++) begin
      cyc(0, 1, 0, 0);
      chk("t2_seg", 32'(seg), 32'(e2[(i / 4) % 6]));
      chk("t2_fd", 32'(frame_done), 32'(i == 24));
    end

    for (int i = 0; i <= 24; i++) cyc(0, 1, i == 9, 24'hFFFFFF);
    chk("t3_seg", 32'(seg), 32'h8E);

    for (int i = 0; i < 24; i++) cyc(0, 1, i == 23, 24'h00000A);
    chk("t4_code", 32'(code), 32'd1);
    chk("t4_seg", 32'(seg), 32'h88);

    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0);
    chk("t5_pre", 32'(code), 32'd4);
    cyc(0, 0, 0, 0);
    chk("t5_code", 32'(code), 32'd0);
    chk("t5_en", 32'(en), 32'd0);
    chk("t5_seg", 32'(seg), 32'hFF);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      chk("t5_slot", 32'(code), (i < 4) ? 32'd1 : 32'd2);
    end

    cyc(0, 0, 1, 24'h000105);
    for (int i = 0; i < 24; i++) begin
      cyc(0, 1, 0, 0);
      chk("t6_seg", 32'(seg), 32'(e6[i / 4]));
    end

    cyc(1, 1, 1, 24'hABCDEF);
    chk("rst_prio", 32'(code), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      dg = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
      cyc(($urandom % 300) == 0, ($urandom % 40) != 0, ($urandom % 6) == 0, dg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
